pipeline_run_ctrl: RTL and testbench
====================================

Name: pipeline_run_ctrl

Overview:
- Synthesizable run controller for the 5-stage pipeline; replaces fixed-time reset/run windows with a parametrised, counter-driven control FSM.
- Sequences:
  - pipeline reset pulse;
  - run window;
  - drain after halt;
  - cycle-budget timeout.
- Keeps cycle, retire and stall statistics. Sits between top-level control/bench and the Pipeline core.

Parameters:
- CNT_W, 32, width of all statistic counters.
- MAX_CYCLES, 20, cycle budget for RUN+DRAIN before timeout; must be ≥1.
- RST_HOLD, 2, cycles pipe_rst is held asserted after start; must be ≥1.
- NUM_STAGES, 5, pipeline depth; drain length = NUM_STAGES cycles.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- halt_seen  in  1  halt instruction entered the pipe (IF stage).
- retire_valid  in  1  an instruction retired (WB) this cycle.
- stall  in  1  pipeline stalled this cycle.
- pipe_rst  out  1  active-high reset to Pipeline core.
- running  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- timeout  out  1  sticky; run ended by budget, not halt.
- cycle_cnt  out  CNT_W  cycles spent in RUN+DRAIN.
- retire_cnt  out  CNT_W  retired instructions during RUN+DRAIN.

Behaviour:
- RST low (async): state=IDLE, pipe_rst=1, running=0, done=0, timeout=0, all counters 0. Release is synchronous to the next CLK edge.
- States: IDLE, RSTHOLD, RUN, DRAIN, DONE. Encoding is one-hot or binary, implementer's choice.
- IDLE: pipe_rst=1. start -> RSTHOLD. On that edge, clear counters, timeout and the hold counter.
- RSTHOLD: pipe_rst=1 for exactly RST_HOLD cycles, then RUN. First RUN cycle has pipe_rst=0.
- RUN: pipe_rst=0.
  - Each cycle, cycle_cnt+1.
  - retire_valid -> retire_cnt+1.
  - halt_seen -> DRAIN, with drain counter loaded to NUM_STAGES.
- DRAIN:
  - Counters keep counting; halt_seen is ignored.
  - After NUM_STAGES cycles -> DONE.
- Timeout: in RUN or DRAIN, if cycle_cnt == MAX_CYCLES-1 on an edge, the next state is DONE with timeout=1. Timeout has priority over halt_seen and drain completion in the same cycle.
- DONE:
  - pipe_rst=1 (core frozen in reset); done=1.
  - Counters and timeout hold.
  - start -> RSTHOLD, clearing counters and timeout.
- start outside IDLE/DONE is ignored.
- Counters saturate at all-ones and never wrap.
- Outputs are registered; no combinational input-to-output paths.
- RST asserted mid-run aborts immediately to IDLE reset values.

Optional Feature:
- Macro PIPE_RUN_STALL_CNT_EN.
- Defined: extra output port stall_cnt (out, CNT_W).
  - Increments when stall=1 in RUN or DRAIN.
  - Cleared with the other counters; saturating.
- Undefined: port and counter are absent and the stall input is unused (lint waiver).

Decomposition:
- Shared package pipeline_run_pkg holds:
  - state typedef/localparams (ST_IDLE, ST_RSTHOLD, ST_RUN, ST_DRAIN, ST_DONE);
  - default CNT_W;
  - a saturating-increment function.
- One natural sub-module, sat_counter: parametrised width, with clear, enable and saturating increment. Instantiated for cycle, retire and optional stall counters.

Test Plan:
- Reset: RST=0 at t=0, release at 2 ns -> pipe_rst=1, running=0, done=0, counters 0, state IDLE; no start -> stays IDLE indefinitely.
- Halt path: defaults, start pulse, halt_seen pulsed in 6th RUN cycle, retire_valid every RUN/DRAIN cycle -> pipe_rst low after 2 hold cycles; DRAIN 5 cycles; done=1, timeout=0, cycle_cnt=11, retire_cnt=11.
- Timeout: MAX_CYCLES=20, start, no halt -> DONE after 20 RUN cycles, timeout=1, cycle_cnt=20. Repeat with halt_seen in RUN cycle 18 -> timeout still wins at cycle 20.
- Restart: from DONE, start -> counters and timeout clear on that edge, pipe_rst held exactly RST_HOLD cycles. Start pulses during RUN are ignored (cycle_cnt unaffected).
- Saturation: CNT_W=4, MAX_CYCLES=40 -> cycle_cnt sticks at 15, no wrap, timeout at cycle 40.
- Async abort + feature: with PIPE_RUN_STALL_CNT_EN, stall high 3 cycles in RUN -> stall_cnt=3. RST low mid-DRAIN, between clock edges -> outputs reach reset values immediately.

Source files
------------

// File: rtl/pipeline_run_pkg.sv
// Shared types for the pipeline run controller: FSM state encoding, default
// counter width and a width-generic saturating increment.
package pipeline_run_pkg;

    localparam int DEF_CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RSTHOLD = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Operates on a 64-bit carrier so any counter width up to 64 can share it.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/pipeline_run_ctrl_if.sv
// Control/status bundle between the run controller and its host.
// The stall_cnt member exists only when PIPE_RUN_STALL_CNT_EN is defined.
interface pipeline_run_ctrl_if
    import pipeline_run_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             halt_seen;
    logic             retire_valid;
    logic             stall;
    logic             pipe_rst;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
`ifdef PIPE_RUN_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output start, halt_seen, retire_valid, stall,
        input  pipe_rst, running, done, timeout, cycle_cnt, retire_cnt, stall_cnt
    );
    modport slave (
        input  start, halt_seen, retire_valid, stall,
        output pipe_rst, running, done, timeout, cycle_cnt, retire_cnt, stall_cnt
    );
`else
    modport master (
        output start, halt_seen, retire_valid, stall,
        input  pipe_rst, running, done, timeout, cycle_cnt, retire_cnt
    );
    modport slave (
        input  start, halt_seen, retire_valid, stall,
        output pipe_rst, running, done, timeout, cycle_cnt, retire_cnt
    );
`endif

endinterface

// File: rtl/sat_counter.sv
// Statistic counter with synchronous clear (priority over enable) that
// sticks at all-ones instead of wrapping.
module sat_counter
    import pipeline_run_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = W'(sat_inc(64'(cnt_q), W));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller for the 5-stage pipeline: reset hold, run, drain after halt,
// cycle-budget timeout. Define PIPE_RUN_STALL_CNT_EN to add the stall counter.
module pipeline_run_ctrl
    import pipeline_run_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_CYCLES = 20,
    parameter int RST_HOLD   = 2,
    parameter int NUM_STAGES = 5
) (
    input logic                CLK,
    input logic                RST,
    pipeline_run_ctrl_if.slave bus
);

    // The budget counter is separate from cycle_cnt so timeout still fires
    // when the statistic counter has saturated at a narrow CNT_W.
    localparam int BUD_W  = $clog2(MAX_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int DRN_W  = $clog2(NUM_STAGES + 1);

    state_t            state_q, state_d;
    logic [BUD_W-1:0]  budget_q, budget_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              pipe_rst_q, pipe_rst_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              active;
    logic              launch;
    logic [CNT_W-1:0]  cycle_cnt_w;
    logic [CNT_W-1:0]  retire_cnt_w;

    always_comb begin
        state_d   = state_q;
        budget_d  = budget_q;
        hold_d    = hold_q;
        drain_d   = drain_q;
        timeout_d = timeout_q;
        launch    = 1'b0;
        active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);

        if (active) begin
            budget_d = budget_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    launch    = 1'b1;
                    state_d   = ST_RSTHOLD;
                    hold_d    = '0;
                    budget_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_RSTHOLD: begin
                if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.halt_seen) begin
                    state_d = ST_DRAIN;
                    drain_d = DRN_W'(NUM_STAGES);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Budget exhaustion overrides halt entry and drain completion.
        if (active && (budget_q == BUD_W'(MAX_CYCLES - 1))) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
        end

        running_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
        pipe_rst_d = !running_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            budget_q   <= '0;
            hold_q     <= '0;
            drain_q    <= '0;
            pipe_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            budget_q   <= budget_d;
            hold_q     <= hold_d;
            drain_q    <= drain_d;
            pipe_rst_q <= pipe_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (launch),
        .en  (active),
        .cnt (cycle_cnt_w)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (launch),
        .en  (active && bus.retire_valid),
        .cnt (retire_cnt_w)
    );

`ifdef PIPE_RUN_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_w;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (launch),
        .en  (active && bus.stall),
        .cnt (stall_cnt_w)
    );

    assign bus.stall_cnt = stall_cnt_w;
`else
    logic unused_stall;
    assign unused_stall = bus.stall;
`endif

    assign bus.pipe_rst   = pipe_rst_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycle_cnt  = cycle_cnt_w;
    assign bus.retire_cnt = retire_cnt_w;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: a default instance and a narrow-counter instance
// (CNT_W=4, MAX_CYCLES=40). Stall counts are checked when PIPE_RUN_STALL_CNT_EN is defined.
module tb_pipeline_run_ctrl;
    import pipeline_run_pkg::*;

    localparam int CW_A  = 32;
    localparam int MAX_A = 20;
    localparam int CW_B  = 4;
    localparam int MAX_B = 40;
    localparam int HOLD  = 2;
    localparam int NS    = 5;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic start = 1'b0;
    logic halt_seen = 1'b0;
    logic retire_valid = 1'b0;
    logic stall = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    pipeline_run_ctrl_if #(.CNT_W(CW_A)) a_if ();
    pipeline_run_ctrl_if #(.CNT_W(CW_B)) b_if ();

    assign a_if.start        = start & ~sel;
    assign a_if.halt_seen    = halt_seen;
    assign a_if.retire_valid = retire_valid;
    assign a_if.stall        = stall;
    assign b_if.start        = start & sel;
    assign b_if.halt_seen    = halt_seen;
    assign b_if.retire_valid = retire_valid;
    assign b_if.stall        = stall;

    pipeline_run_ctrl #(.CNT_W(CW_A), .MAX_CYCLES(MAX_A), .RST_HOLD(HOLD), .NUM_STAGES(NS)) dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (a_if)
    );

    pipeline_run_ctrl #(.CNT_W(CW_B), .MAX_CYCLES(MAX_B), .RST_HOLD(HOLD), .NUM_STAGES(NS)) dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (b_if)
    );

    // Observation mux: sel chooses which instance the checks look at.
    logic [63:0] o_pipe_rst, o_running, o_done, o_timeout, o_cyc, o_ret, o_stl;
    always_comb begin
        o_pipe_rst = sel ? 64'(b_if.pipe_rst)   : 64'(a_if.pipe_rst);
        o_running  = sel ? 64'(b_if.running)    : 64'(a_if.running);
        o_done     = sel ? 64'(b_if.done)       : 64'(a_if.done);
        o_timeout  = sel ? 64'(b_if.timeout)    : 64'(a_if.timeout);
        o_cyc      = sel ? 64'(b_if.cycle_cnt)  : 64'(a_if.cycle_cnt);
        o_ret      = sel ? 64'(b_if.retire_cnt) : 64'(a_if.retire_cnt);
        o_stl      = '0;
`ifdef PIPE_RUN_STALL_CNT_EN
        o_stl      = sel ? 64'(b_if.stall_cnt)  : 64'(a_if.stall_cnt);
`endif
    end

    typedef struct {
        bit sel;   // 0: default instance, 1: narrow instance
        int h;     // RUN/DRAIN cycle with halt_seen (0: never)
        int pat;   // retire pattern: 0 none, 1 every cycle, 2 even cycles
        int st_lo; // stall window (st_lo=0: none)
        int st_hi;
        int sk;    // cycle with a stray start pulse (0: none)
        int len;   // expected RUN+DRAIN cycles until done
        int cyc;
        int ret;
        int to;
        int stl;
    } vec_t;

    typedef struct {
        int idx;
        int len;
        int cyc;
        int ret;
        int to;
        int stl;
    } exp_t;

    vec_t vt[9];
    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start pulse, then confirm clear-on-start and the exact reset-hold length.
    task automatic launch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("launch_pipe_rst", o_pipe_rst, 64'd1);
        chk("launch_running", o_running, 64'd0);
        chk("launch_done", o_done, 64'd0);
        chk("launch_timeout_clear", o_timeout, 64'd0);
        chk("launch_cycle_clear", o_cyc, 64'd0);
        chk("launch_retire_clear", o_ret, 64'd0);
        for (int i = 1; i < HOLD; i++) begin
            @(posedge clk); #1;
            chk("hold_pipe_rst", o_pipe_rst, 64'd1);
        end
        @(posedge clk); #1;
        chk("run_pipe_rst_low", o_pipe_rst, 64'd0);
        chk("run_running", o_running, 64'd1);
    endtask

    task automatic run_vec(input int i);
        exp_t e;
        exp_t g;
        int   k;
        bit   seen;
        sel = vt[i].sel;
        e.idx = i; e.len = vt[i].len; e.cyc = vt[i].cyc;
        e.ret = vt[i].ret; e.to = vt[i].to; e.stl = vt[i].stl;
        sb.push_back(e);
        launch();
        seen = 1'b0;
        k = 0;
        for (int c = 1; c <= 80 && !seen; c++) begin
            halt_seen    = (c == vt[i].h);
            retire_valid = (vt[i].pat == 1) || (vt[i].pat == 2 && (c % 2) == 0);
            stall        = (vt[i].st_lo != 0) && (c >= vt[i].st_lo) && (c <= vt[i].st_hi);
            start        = (c == vt[i].sk);
            @(posedge clk); #1;
            if (o_done == 64'd1) begin
                seen = 1'b1;
                k = c;
            end
        end
        halt_seen = 1'b0; retire_valid = 1'b0; stall = 1'b0; start = 1'b0;
        chk("done_within_bound", 64'(seen), 64'd1);
        g = sb.pop_front();
        chk("run_length", 64'(k), 64'(g.len));
        chk("cycle_cnt", o_cyc, 64'(g.cyc));
        chk("retire_cnt", o_ret, 64'(g.ret));
        chk("timeout", o_timeout, 64'(g.to));
        chk("done_pipe_rst", o_pipe_rst, 64'd1);
        chk("done_running", o_running, 64'd0);
`ifdef PIPE_RUN_STALL_CNT_EN
        chk("stall_cnt", o_stl, 64'(g.stl));
`endif
        $display("run %0d dut=%0d len=%0d cycle_cnt=%0d retire_cnt=%0d timeout=%0d stall_cnt=%0d",
                 g.idx, sel, k, o_cyc, o_ret, o_timeout, o_stl);
    endtask

    initial begin
        //          sel h   pat lo hi  sk len cyc ret to stl
        vt[0] = '{0,  6,  1, 0, 0,  0, 11, 11, 11, 0, 0};
        vt[1] = '{0,  0,  1, 0, 0,  0, 20, 20, 20, 1, 0};
        vt[2] = '{0, 18,  1, 0, 0,  0, 20, 20, 20, 1, 0};
        vt[3] = '{0,  1,  0, 0, 0,  4,  6,  6,  0, 0, 0};
        vt[4] = '{0, 14,  2, 0, 0,  0, 19, 19,  9, 0, 0};
        vt[5] = '{0, 15,  0, 0, 0,  0, 20, 20,  0, 1, 0};
        vt[6] = '{0,  6,  1, 2, 4,  3, 11, 11, 11, 0, 3};
        vt[7] = '{0, 16,  2, 1, 30, 0, 20, 20, 10, 1, 20};
        vt[8] = '{1,  0,  1, 1, 30, 0, 40, 15, 15, 1, 15};

        // Asynchronous reset before the first clock edge.
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        sel = 1'b0;
        #0;
        chk("rst_a_pipe_rst", o_pipe_rst, 64'd1);
        chk("rst_a_running", o_running, 64'd0);
        chk("rst_a_done", o_done, 64'd0);
        chk("rst_a_timeout", o_timeout, 64'd0);
        chk("rst_a_cycle_cnt", o_cyc, 64'd0);
        chk("rst_a_retire_cnt", o_ret, 64'd0);
        sel = 1'b1;
        #1;
        chk("rst_b_pipe_rst", o_pipe_rst, 64'd1);
        chk("rst_b_done", o_done, 64'd0);
        chk("rst_b_cycle_cnt", o_cyc, 64'd0);
        sel = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // No start: remain idle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("idle_pipe_rst", o_pipe_rst, 64'd1);
            chk("idle_running", o_running, 64'd0);
            chk("idle_done", o_done, 64'd0);
        end

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // Abort mid-DRAIN with reset asserted between clock edges.
        sel = 1'b0;
        launch();
        for (int c = 1; c <= 5; c++) begin
            halt_seen    = (c == 3);
            retire_valid = 1'b1;
            @(posedge clk); #1;
        end
        halt_seen = 1'b0;
        retire_valid = 1'b0;
        chk("abort_pre_cycle_cnt", o_cyc, 64'd5);
        chk("abort_pre_running", o_running, 64'd1);
        #3;
        rst_a = 1'b0;
        #1;
        chk("abort_pipe_rst", o_pipe_rst, 64'd1);
        chk("abort_running", o_running, 64'd0);
        chk("abort_done", o_done, 64'd0);
        chk("abort_timeout", o_timeout, 64'd0);
        chk("abort_cycle_cnt", o_cyc, 64'd0);
        chk("abort_retire_cnt", o_ret, 64'd0);
        #2;
        rst_a = 1'b1;
        @(posedge clk); #1;
        chk("post_abort_pipe_rst", o_pipe_rst, 64'd1);
        chk("post_abort_running", o_running, 64'd0);
        chk("post_abort_done", o_done, 64'd0);

        // Recovery from IDLE after the abort.
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
